stripe_arbiter: RTL and testbench
=================================

Name: stripe_arbiter

Overview:
- Packet-level round-robin arbiter sharing the two-lane byte striper between two byte-stream requesters.
- Sits directly upstream of the striper, in the clk_2f domain; drives the striper's valid_in/data_in.
- Holds a grant for a whole packet (valid/last framing).
- Pads odd-length packets with one filler byte so every packet occupies both lanes equally.

Parameters:
- PAD_BYTE, 8'hBC, filler byte appended to odd-length packets.
- CNT_W, 8, width of the saturating packet and pad statistics counters.

Ports:
- clk_2f  input  1  byte-rate clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately when low.
- valid_0  input  1  requester 0 byte valid.
- data_0  input  8  requester 0 byte.
- last_0  input  1  requester 0 final byte of packet (qualified by valid_0).
- ready_0  output  1  requester 0 byte accepted this cycle when valid_0 && ready_0.
- valid_1, data_1, last_1, ready_1: same as above, for requester 1.
- valid_out  output  1  to striper valid_in.
- data_out  output  8  to striper data_in.
- grant  output  2  one-hot owner of the striper (2'b00 when none).
- pkt_cnt  output  CNT_W  completed packets, saturates at all-ones.
- pad_cnt  output  CNT_W  pad bytes inserted, saturates at all-ones.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, prio=0, odd=0, valid_out=0, data_out=8'h00, grant=2'b00, pkt_cnt=0, pad_cnt=0.
- States: IDLE, GNT0, GNT1, PAD. grant=2'b01 in GNT0, 2'b10 in GNT1, 2'b00 otherwise.
- ready_x is combinational and equals (state==GNTx). ready_x never depends on valid_x.
- IDLE transitions:
  - If valid_0 and valid_1 are both high, go to GNT(prio).
  - Else go to GNT0 if valid_0, GNT1 if valid_1, otherwise stay in IDLE.
  - IDLE always drives valid_out<=0.
  - Grant is registered, so there is always at least one bubble cycle between packets.
- GNTx with valid_x==1 (byte accepted):
  - data_out<=data_x, valid_out<=1 on the same edge; latency is 1 clk_2f cycle.
  - odd<=~odd.
- GNTx with valid_x==0: valid_out<=0; stay in GNTx. A mid-packet bubble is passed through.
- Accepted byte with last_x==1:
  - If the packet length is odd (odd==0 before this byte), go to PAD.
  - Otherwise go to IDLE, set prio<=~x, and increment pkt_cnt.
- PAD:
  - data_out<=PAD_BYTE, valid_out<=1, pad_cnt++, odd<=0.
  - Then go to IDLE, set prio<=~x, and increment pkt_cnt.
  - Both ready_x are 0 in PAD.
- odd is cleared on every transition into IDLE.
- A single-byte packet (valid and last in the first cycle) is legal and is always padded.
- The non-granted requester is ignored, whatever its valid_x. Its data is never sampled and it sees no ready.
- Counters saturate; they do not wrap.
- Reset asserted mid-packet or mid-PAD:
  - The partial packet is dropped, with no pad and no pkt_cnt increment.
  - valid_out drops asynchronously.
  - After release, arbitration restarts from IDLE with prio=0.
- data_out holds its last value while valid_out==0.

Optional Feature:
- Macro: STRIPE_ARBITER_PAD_EN.
- Defined: odd-length packets are padded as described; every packet's length on valid_out is even.
- Not defined:
  - The PAD state is not synthesized.
  - last with odd length goes straight to IDLE.
  - pad_cnt is tied to 0.
  - Packets pass with their native length, and lane balancing is the striper's problem.

Test Plan:
- Reset check:
  - Stimulus: hold reset=0 with valid_0=valid_1=1.
  - Required: valid_out=0, grant=00, ready_0=ready_1=0, counters 0.
- Even packet, requester 0:
  - Stimulus: 4-byte packet A0,A1,A2,A3 (last on A3) on requester 0 only.
  - Required: grant=01 one cycle after valid_0 rises; valid_out high for 4 consecutive cycles carrying A0..A3, each 1 cycle after acceptance; then IDLE; pkt_cnt=1; pad_cnt=0.
- Odd packet with pad (PAD_EN defined):
  - Stimulus: 3-byte packet 11,22,33 on requester 1.
  - Required: data_out sequence 11,22,33,BC with valid_out high; pad_cnt=1; pkt_cnt=1.
  - Same stimulus without the macro: sequence 11,22,33 only; pad_cnt=0.
- Simultaneous requests:
  - Stimulus: both requesters continuously present 2-byte packets (0x0A,0x0B and 0x1A,0x1B).
  - Required: packets alternate 0,1,0,1 starting with requester 0; exactly one bubble (valid_out=0) between packets; no interleaving of bytes within a packet.
- Mid-packet stall:
  - Stimulus: requester 0 drops valid_0 for 2 cycles between bytes 1 and 2 of a 4-byte packet, while requester 1 requests.
  - Required: grant stays 01; valid_out shows a 2-cycle gap; ready_1 stays 0 until requester 0's last byte.
- Reset mid-packet:
  - Stimulus: assert reset after 2 bytes of a 5-byte packet.
  - Required: valid_out falls without a clock edge; pkt_cnt unchanged (0); after release a new request is served starting at IDLE with prio=0.

Source files
------------

// File: rtl/stripe_arbiter.sv
// Packet-level round-robin arbiter feeding the two-lane byte striper from two requesters.
// Optional macro STRIPE_ARBITER_PAD_EN: pad odd-length packets with PAD_BYTE so both lanes stay balanced.
module stripe_arbiter #(
  parameter logic [7:0] PAD_BYTE = 8'hBC,
  parameter int         CNT_W    = 8
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             valid_0,
  input  logic [7:0]       data_0,
  input  logic             last_0,
  output logic             ready_0,
  input  logic             valid_1,
  input  logic [7:0]       data_1,
  input  logic             last_1,
  output logic             ready_1,
  output logic             valid_out,
  output logic [7:0]       data_out,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] pad_cnt
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, PAD} state_t;

  state_t     state, state_nxt;
  logic       prio, odd, owner;
  logic       take, tlast, is_pad, done;
  logic [7:0] tdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign ready_0 = (state == GNT0);
  assign ready_1 = (state == GNT1);
  assign grant   = {state == GNT1, state == GNT0};

  // Only the granted requester is ever sampled.
  assign take  = (ready_0 && valid_0) || (ready_1 && valid_1);
  assign tdata = ready_1 ? data_1 : data_0;
  assign tlast = ready_1 ? last_1 : last_0;

`ifdef STRIPE_ARBITER_PAD_EN
  assign is_pad = (state == PAD);
`else
  assign is_pad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (valid_0 && valid_1) state_nxt = prio ? GNT1 : GNT0;
        else if (valid_0)       state_nxt = GNT0;
        else if (valid_1)       state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (take && tlast) begin
`ifdef STRIPE_ARBITER_PAD_EN
          // odd==0 before the last byte means the packet length is odd.
          state_nxt = odd ? IDLE : PAD;
`else
          state_nxt = IDLE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done = is_pad || (take && tlast && (state_nxt == IDLE));

  // Stage p0 -> output register: one clk_2f of latency from acceptance to valid_out.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      odd       <= 1'b0;
      owner     <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= 8'h00;
      pkt_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      valid_out <= take || is_pad;
      if (take)        data_out <= tdata;
      else if (is_pad) data_out <= PAD_BYTE;
      if (state_nxt == IDLE) odd <= 1'b0;
      else if (take)         odd <= ~odd;
      if (state == IDLE && state_nxt != IDLE) owner <= (state_nxt == GNT1);
      if (done) begin
        prio    <= ~owner;
        pkt_cnt <= sat_inc(pkt_cnt);
      end
    end
  end

`ifdef STRIPE_ARBITER_PAD_EN
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset)      pad_cnt <= '0;
    else if (is_pad) pad_cnt <= sat_inc(pad_cnt);
  end
`else
  assign pad_cnt = '0;
`endif

endmodule

// File: tb/tb_stripe_arbiter.sv
// Directed bench for stripe_arbiter: reset, even/odd packets, round-robin, stall, reset mid-packet.
module tb_stripe_arbiter;

  logic       clk_2f = 1'b0;
  logic       reset;
  logic       valid_0, last_0, ready_0;
  logic       valid_1, last_1, ready_1;
  logic [7:0] data_0, data_1, data_out;
  logic       valid_out;
  logic [1:0] grant;
  logic [7:0] pkt_cnt, pad_cnt;

  int total = 0;
  int bad   = 0;

  stripe_arbiter #(.PAD_BYTE(8'hBC), .CNT_W(8)) dut (
    .clk_2f(clk_2f), .reset(reset),
    .valid_0(valid_0), .data_0(data_0), .last_0(last_0), .ready_0(ready_0),
    .valid_1(valid_1), .data_1(data_1), .last_1(last_1), .ready_1(ready_1),
    .valid_out(valid_out), .data_out(data_out), .grant(grant),
    .pkt_cnt(pkt_cnt), .pad_cnt(pad_cnt)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] pa [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic       exp_v [12] = '{0,1,1,0,1,1,0,1,1,0,1,1};
  logic [7:0] exp_d [12] = '{8'h00,8'h0A,8'h0B,8'h00,8'h1A,8'h1B,8'h00,8'h0A,8'h0B,8'h00,8'h1A,8'h1B};
  logic [1:0] exp_g [12] = '{2'b01,2'b01,2'b00,2'b10,2'b10,2'b00,2'b01,2'b01,2'b00,2'b10,2'b10,2'b00};

  initial begin
    logic idx0, idx1, r0, r1;
    reset = 1'b0;
    valid_0 = 1'b1; data_0 = 8'h00; last_0 = 1'b0;
    valid_1 = 1'b1; data_1 = 8'h00; last_1 = 1'b0;

    // Reset held with both requesters asking
    tick(); tick();
    chk("rst_valid_out", valid_out, 0);
    chk("rst_grant", grant, 2'b00);
    chk("rst_ready_0", ready_0, 0);
    chk("rst_ready_1", ready_1, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_pad_cnt", pad_cnt, 0);
    chk("rst_data_out", data_out, 8'h00);

    reset = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0;
    tick();

    // Even 4-byte packet on requester 0
    valid_0 = 1'b1; data_0 = pa[0];
    chk("even_idle_grant", grant, 2'b00);
    tick();
    chk("even_grant", grant, 2'b01);
    chk("even_ready_0", ready_0, 1);
    chk("even_bubble", valid_out, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("even_valid", valid_out, 1);
      chk("even_data", data_out, pa[i]);
      if (i < 3) begin
        data_0 = pa[i+1]; last_0 = (i == 2);
        tick();
      end
    end
    valid_0 = 1'b0; last_0 = 1'b0;
    chk("even_grant_done", grant, 2'b00);
    chk("even_pkt_cnt", pkt_cnt, 1);
    chk("even_pad_cnt", pad_cnt, 0);
    tick();
    chk("even_tail_idle", valid_out, 0);

    // Odd 3-byte packet on requester 1
    valid_1 = 1'b1; data_1 = 8'h11;
    tick();
    chk("odd_grant", grant, 2'b10);
    tick();
    chk("odd_b0", data_out, 8'h11);
    data_1 = 8'h22;
    tick();
    chk("odd_b1", data_out, 8'h22);
    data_1 = 8'h33; last_1 = 1'b1;
    tick();
    chk("odd_b2_valid", valid_out, 1);
    chk("odd_b2", data_out, 8'h33);
    valid_1 = 1'b0; last_1 = 1'b0;
    tick();
`ifdef STRIPE_ARBITER_PAD_EN
    chk("odd_pad_valid", valid_out, 1);
    chk("odd_pad_data", data_out, 8'hBC);
    chk("odd_pad_cnt", pad_cnt, 1);
    tick();
`endif
    chk("odd_tail_idle", valid_out, 0);
    chk("odd_pkt_cnt", pkt_cnt, 2);
`ifndef STRIPE_ARBITER_PAD_EN
    chk("odd_nopad_cnt", pad_cnt, 0);
`endif

    // Both requesters continuously offering 2-byte packets
    idx0 = 1'b0; idx1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      valid_0 = 1'b1; data_0 = idx0 ? 8'h0B : 8'h0A; last_0 = idx0;
      valid_1 = 1'b1; data_1 = idx1 ? 8'h1B : 8'h1A; last_1 = idx1;
      r0 = ready_0; r1 = ready_1;
      tick();
      if (r0) idx0 = ~idx0;
      if (r1) idx1 = ~idx1;
      chk("rr_valid", valid_out, exp_v[k]);
      chk("rr_grant", grant, exp_g[k]);
      if (exp_v[k]) chk("rr_data", data_out, exp_d[k]);
    end
    chk("rr_pkt_cnt", pkt_cnt, 6);
    valid_0 = 1'b0; last_0 = 1'b0; valid_1 = 1'b0; last_1 = 1'b0;
    tick();

    // Mid-packet stall on requester 0 while requester 1 waits
    valid_0 = 1'b1; data_0 = 8'hB0;
    valid_1 = 1'b1; data_1 = 8'hC0;
    tick();
    chk("stall_grant", grant, 2'b01);
    chk("stall_ready_1_a", ready_1, 0);
    tick();
    chk("stall_b0", data_out, 8'hB0);
    data_0 = 8'hB1;
    tick();
    chk("stall_b1", data_out, 8'hB1);
    valid_0 = 1'b0;
    tick();
    chk("stall_gap1", valid_out, 0);
    chk("stall_grant_hold1", grant, 2'b01);
    chk("stall_ready_1_b", ready_1, 0);
    tick();
    chk("stall_gap2", valid_out, 0);
    chk("stall_grant_hold2", grant, 2'b01);
    valid_0 = 1'b1; data_0 = 8'hB2;
    tick();
    chk("stall_b2", data_out, 8'hB2);
    chk("stall_ready_1_c", ready_1, 0);
    data_0 = 8'hB3; last_0 = 1'b1;
    tick();
    chk("stall_b3", data_out, 8'hB3);
    chk("stall_pkt_cnt", pkt_cnt, 7);
    valid_0 = 1'b0; last_0 = 1'b0;
    tick();
    chk("stall_grant_1", grant, 2'b10);
    chk("stall_ready_1_d", ready_1, 1);

    // Requester 1 starts a 5-byte packet; reset lands after two bytes
    tick();
    chk("rmid_c0", data_out, 8'hC0);
    data_1 = 8'hC1;
    tick();
    chk("rmid_c1_valid", valid_out, 1);
    chk("rmid_c1", data_out, 8'hC1);
    reset = 1'b0;
    #1;
    chk("rmid_async_valid", valid_out, 0);
    chk("rmid_async_grant", grant, 2'b00);
    chk("rmid_async_ready_1", ready_1, 0);
    chk("rmid_pkt_cnt", pkt_cnt, 0);
    chk("rmid_data_out", data_out, 8'h00);
    tick();
    // Prio was 1 before reset; a restart at prio=0 must pick requester 0
    reset = 1'b1;
    valid_0 = 1'b1; data_0 = 8'hE0; last_0 = 1'b1;
    tick();
    chk("rrel_grant", grant, 2'b01);
    chk("rrel_ready_1", ready_1, 0);
    chk("rrel_bubble", valid_out, 0);
    tick();
    chk("rrel_e0", data_out, 8'hE0);
    chk("rrel_e0_valid", valid_out, 1);
    valid_0 = 1'b0; last_0 = 1'b0; valid_1 = 1'b0;
    tick();
`ifdef STRIPE_ARBITER_PAD_EN
    chk("rrel_pad_valid", valid_out, 1);
    chk("rrel_pad_data", data_out, 8'hBC);
    chk("rrel_pad_cnt", pad_cnt, 1);
    tick();
`else
    chk("rrel_nopad_cnt", pad_cnt, 0);
`endif
    chk("rrel_idle", valid_out, 0);
    chk("rrel_pkt_cnt", pkt_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
